// File: rtl/uart_link_pkg.sv
// Shared definitions for the host-side UART link: ASCII framing constants,
// frame lengths, TX/RX state encodings and small byte-classification helpers.
package uart_link_pkg;

  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_ONE   = 8'h31;
  localparam logic [7:0] CH_NINE  = 8'h39;

  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_L = 8'h4C;

  localparam int CMD_LEN  = 5;
  localparam int STAT_LEN = 9;

  typedef enum logic [2:0] {
    TX_IDLE, TX_CHECK, TX_LOAD, TX_SEND, TX_FIN
  } tx_state_t;

  // One state per expected byte of "S:TTHHFH/".
  typedef enum logic [3:0] {
    RX_S0, RX_S1, RX_S2, RX_S3, RX_S4, RX_S5, RX_S6, RX_S7, RX_S8
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_ZERO) && (b <= CH_NINE);
  endfunction

  function automatic logic is_flag(input logic [7:0] b);
    return (b == CH_ZERO) || (b == CH_ONE);
  endfunction

  // LED command only takes on/off digits; threshold commands take 0..9.
  function automatic logic cmd_legal(input logic [7:0] code,
                                     input logic [3:0] v0,
                                     input logic [3:0] v1);
    logic known;
    known = (code == CMD_A) || (code == CMD_B) || (code == CMD_C) ||
            (code == CMD_D) || (code == CMD_L);
    return known && (v0 <= 4'd9) && (v1 <= 4'd9) &&
           !((code == CMD_L) && ((v0 > 4'd1) || (v1 > 4'd1)));
  endfunction

  // Byte at position idx of the command frame "[cmd][v0]:[v1]\n".
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                          input logic [7:0] code,
                                          input logic [3:0] v0,
                                          input logic [3:0] v1);
    case (idx)
      3'd0:    return code;
      3'd1:    return CH_ZERO + {4'h0, v0};
      3'd2:    return CH_COLON;
      3'd3:    return CH_ZERO + {4'h0, v1};
      default: return CH_LF;
    endcase
  endfunction

endpackage

// File: rtl/uart_host_link_parser.sv
// status_frame_parser: walks the board's "S:TTHHFH/" status frame one byte
// per rx_done, captures digits into shadow registers and publishes them only
// when the terminator arrives. Optional inter-byte timeout: RX_TIMEOUT_EN.
module status_frame_parser
  import uart_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int TIMER_W        = 17
) (
  input  logic       clk_1Mhz,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [6:0] temperature,
  output logic [6:0] humidity,
  output logic       fan_state,
  output logic       hum_state,
  output logic       stat_valid,
  output logic       frame_err
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (1 << TIMER_W)) ||
      (int'(RX_S8) + 1 != STAT_LEN)) begin : g_bad_cfg
    $error("status_frame_parser: TIMER_W too narrow for TIMEOUT_CYCLES");
  end

  rx_state_t  state, next_state;
  logic       commit, err;
  logic [3:0] t1_sh, t0_sh, h1_sh, h0_sh;
  logic       fan_sh, hum_sh;
  logic       timeout;

`ifdef RX_TIMEOUT_EN
  logic [TIMER_W-1:0] timer;

  assign timeout = (state != RX_S0) && !rx_done &&
                   (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Idle-gap timer: restarts on every byte, parked at 0 while hunting for 'S'.
  always_ff @(posedge clk_1Mhz or negedge rst_n) begin
    if (!rst_n)                                   timer <= '0;
    else if (rx_done || timeout || state == RX_S0) timer <= '0;
    else                                          timer <= timer + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Parser state register.
  // NOTE: state and data registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_1Mhz or negedge rst_n) begin
    if (!rst_n) state <= RX_S0;
    else        state <= next_state;
  end

  // Next-state decode: validate the current byte against its frame slot.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    logic ok;
    next_state = state;
    commit     = 1'b0;
    err        = 1'b0;
    ok         = 1'b0;
    case (state)
      RX_S0:                      ok = (rx_data == CH_S);
      RX_S1:                      ok = (rx_data == CH_COLON);
      RX_S2, RX_S3, RX_S4, RX_S5: ok = is_digit(rx_data);
      RX_S6, RX_S7:               ok = is_flag(rx_data);
      RX_S8:                      ok = (rx_data == CH_SLASH);
      default:                    ok = 1'b0;
    endcase
    if (timeout) begin
      next_state = RX_S0;
      err        = 1'b1;
    end else if (rx_done) begin
      if (state == RX_S0) begin
        // Line noise between frames is not an error.
        next_state = ok ? RX_S1 : RX_S0;
      end else if (ok) begin
        commit     = (state == RX_S8);
        next_state = (state == RX_S8) ? RX_S0 : rx_state_t'(state + 4'd1);
      end else begin
        // A stray 'S' is most likely the start of the next frame: resync.
        err        = 1'b1;
        next_state = (rx_data == CH_S) ? RX_S1 : RX_S0;
      end
    end
  end

  // Shadow capture of each field as its byte arrives.
  // NOTE: shadow registers are reset too; they are few flops and keep the
  // published outputs deterministic even for a frame that starts out of reset.
  always_ff @(posedge clk_1Mhz or negedge rst_n) begin
    if (!rst_n) begin
      t1_sh  <= '0;
      t0_sh  <= '0;
      h1_sh  <= '0;
      h0_sh  <= '0;
      fan_sh <= 1'b0;
      hum_sh <= 1'b0;
    end else if (rx_done) begin
      case (state)
        RX_S2:   t1_sh  <= rx_data[3:0];
        RX_S3:   t0_sh  <= rx_data[3:0];
        RX_S4:   h1_sh  <= rx_data[3:0];
        RX_S5:   h0_sh  <= rx_data[3:0];
        RX_S6:   fan_sh <= rx_data[0];
        RX_S7:   hum_sh <= rx_data[0];
        default: ;
      endcase
    end
  end

  // Publish a good frame and raise the status/error strobes.
  always_ff @(posedge clk_1Mhz or negedge rst_n) begin
    if (!rst_n) begin
      temperature <= '0;
      humidity    <= '0;
      fan_state   <= 1'b0;
      hum_state   <= 1'b0;
      stat_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      stat_valid <= commit;
      frame_err  <= err;
      if (commit) begin
        temperature <= 7'(t1_sh) * 7'd10 + 7'(t0_sh);
        humidity    <= 7'(h1_sh) * 7'd10 + 7'(h0_sh);
        fan_state   <= fan_sh;
        hum_state   <= hum_sh;
      end
    end
  end

endmodule

// File: rtl/uart_host_link.sv
// uart_host_link: host-side UART link endpoint. Serialises commands into
// "[cmd][v0]:[v1]\n" over a start/busy/done byte interface and hands received
// bytes to status_frame_parser. Optional macro: RX_TIMEOUT_EN (parser timeout).
module uart_host_link
  import uart_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int TIMER_W        = 17
) (
  input  logic       clk_1Mhz,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_code,
  input  logic [3:0] cmd_val0,
  input  logic [3:0] cmd_val1,
  output logic       cmd_err,
  output logic       cmd_sent,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [6:0] temperature,
  output logic [6:0] humidity,
  output logic       fan_state,
  output logic       hum_state,
  output logic       stat_valid,
  output logic       frame_err
);

  tx_state_t  state, next_state;
  logic [7:0] code_q;
  logic [3:0] val0_q, val1_q;
  logic [2:0] idx;

  // TX state register.
  always_ff @(posedge clk_1Mhz or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= next_state;
  end

  // TX next-state and handshake strobes.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    cmd_err    = 1'b0;
    cmd_sent   = 1'b0;
    case (state)
      TX_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = TX_CHECK;
      end
      TX_CHECK: begin
        if (cmd_legal(code_q, val0_q, val1_q)) begin
          next_state = TX_LOAD;
        end else begin
          cmd_err    = 1'b1;
          next_state = TX_IDLE;
        end
      end
      TX_LOAD:  if (!tx_busy) next_state = TX_SEND;
      TX_SEND: begin
        if (tx_done) next_state = (idx == 3'(CMD_LEN - 1)) ? TX_FIN : TX_LOAD;
      end
      TX_FIN: begin
        cmd_sent   = 1'b1;
        next_state = TX_IDLE;
      end
      default: next_state = TX_IDLE;
    endcase
  end

  // Command latch, byte index and the byte request held toward uart_tx.
  always_ff @(posedge clk_1Mhz or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= '0;
      val0_q   <= '0;
      val1_q   <= '0;
      idx      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      if (state == TX_IDLE && cmd_valid) begin
        code_q <= cmd_code;
        val0_q <= cmd_val0;
        val1_q <= cmd_val1;
        idx    <= '0;
      end
      if (state == TX_LOAD && !tx_busy) begin
        tx_start <= 1'b1;
        tx_data  <= cmd_byte(idx, code_q, val0_q, val1_q);
      end
      if (state == TX_SEND && tx_done) begin
        tx_start <= 1'b0;
        if (idx != 3'(CMD_LEN - 1)) idx <= idx + 3'd1;
      end
    end
  end

  status_frame_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_parser (
    .clk_1Mhz   (clk_1Mhz),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .temperature(temperature),
    .humidity   (humidity),
    .fan_state  (fan_state),
    .hum_state  (hum_state),
    .stat_valid (stat_valid),
    .frame_err  (frame_err)
  );

endmodule

// File: tb/tb_uart_host_link.sv
// Self-checking bench for uart_host_link: directed and $urandom command and
// status traffic, a behavioural uart_tx responder and a frame-level model.
`timescale 1ns/1ps
module tb_uart_host_link;
  import uart_link_pkg::*;

  logic       clk_1Mhz = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_code;
  logic [3:0] cmd_val0, cmd_val1;
  logic       cmd_err, cmd_sent;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [6:0] temperature, humidity;
  logic       fan_state, hum_state, stat_valid, frame_err;

  int tests = 0;
  int fails = 0;

  // uart_tx responder state and observations
  int         byte_time = 1000;
  int         model_cnt;
  logic [7:0] cur_byte;
  logic [7:0] tx_log[$];
  int         hold_viol = 0;
  int         both_done = 0;

  // expected published status
  int exp_t = 0, exp_h = 0;
  bit exp_f = 1'b0, exp_hm = 1'b0;

  int to_cycle;
  bit to_found;
  int base_both;
  logic [7:0] codes[6];

  always #500 clk_1Mhz = ~clk_1Mhz;

  uart_host_link #(.TIMEOUT_CYCLES(50), .TIMER_W(17)) dut (
    .clk_1Mhz(clk_1Mhz), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_val0(cmd_val0), .cmd_val1(cmd_val1), .cmd_err(cmd_err), .cmd_sent(cmd_sent),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_data(rx_data), .rx_done(rx_done),
    .temperature(temperature), .humidity(humidity), .fan_state(fan_state),
    .hum_state(hum_state), .stat_valid(stat_valid), .frame_err(frame_err)
  );

  // uart_tx model: takes a byte on tx_start when idle, stays busy byte_time
  // cycles, then one done pulse. Logs every byte and any tx_start/tx_data wobble.
  always @(posedge clk_1Mhz or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      model_cnt <= 0;
    end else begin
      tx_done <= 1'b0;
      if (tx_done && rx_done) both_done <= both_done + 1;
      if (tx_busy) begin
        if (!tx_start || tx_data !== cur_byte) hold_viol <= hold_viol + 1;
        if (model_cnt <= 1) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          model_cnt <= model_cnt - 1;
        end
      end else if (tx_start && !tx_done) begin
        tx_log.push_back(tx_data);
        cur_byte  <= tx_data;
        tx_busy   <= 1'b1;
        model_cnt <= byte_time;
      end
    end
  end

  initial begin
    #80_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".temperature"}, temperature, exp_t);
    check({tag, ".humidity"}, humidity, exp_h);
    check({tag, ".fan_state"}, fan_state, exp_f);
    check({tag, ".hum_state"}, hum_state, exp_hm);
  endtask

  // One received byte; optionally lined up with a tx_done pulse.
  task automatic send_rx(input logic [7:0] b, input bit sync, output logic sv, output logic fe);
    if (sync) begin
      for (int c = 0; c < 5000 && !tx_done; c++) @(negedge clk_1Mhz);
    end else begin
      @(negedge clk_1Mhz);
    end
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk_1Mhz);
    rx_done = 1'b0;
    sv = stat_valid;
    fe = frame_err;
  endtask

  // Send a string; frame_err expected only after byte err_at, stat_valid only
  // after byte valid_at (-1 = never). The first nsync bytes ride on tx_done.
  task automatic rx_string(input string s, input int err_at, input int valid_at, input int nsync);
    logic sv, fe;
    for (int i = 0; i < s.len(); i++) begin
      send_rx(s.getc(i), i < nsync, sv, fe);
      check($sformatf("frame_err[%s@%0d]", s, i), fe, i == err_at);
      check($sformatf("stat_valid[%s@%0d]", s, i), sv, i == valid_at);
    end
    @(negedge clk_1Mhz);
    check("stat_valid_width", stat_valid, 0);
    check("frame_err_width", frame_err, 0);
  endtask

  task automatic do_cmd(input logic [7:0] code, input logic [3:0] v0, input logic [3:0] v1);
    bit legal, sent;
    int base, hv, ready_hi, limit;
    logic [7:0] exp_q[$];
    legal = (code inside {CMD_A, CMD_B, CMD_C, CMD_D, CMD_L}) && v0 <= 9 && v1 <= 9 &&
            !(code == CMD_L && (v0 > 1 || v1 > 1));
    base = tx_log.size();
    hv = hold_viol;
    ready_hi = 0;
    sent = 1'b0;
    limit = 8 * (byte_time + 4) + 20;
    @(negedge clk_1Mhz);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_code = code;
    cmd_val0 = v0;
    cmd_val1 = v1;
    @(negedge clk_1Mhz);
    cmd_valid = 1'b0;
    check($sformatf("cmd_err[%0h %0d %0d]", code, v0, v1), cmd_err, !legal);
    if (!legal) begin
      @(negedge clk_1Mhz);
      check("cmd_ready_after_err", cmd_ready, 1);
      check("cmd_err_width", cmd_err, 0);
      check("no_tx_on_err", tx_log.size() - base, 0);
    end else begin
      for (int c = 0; c < limit && !sent; c++) begin
        if (cmd_ready) ready_hi++;
        @(negedge clk_1Mhz);
        if (cmd_sent) sent = 1'b1;
      end
      check("cmd_sent_seen", sent, 1);
      check("cmd_ready_low_in_frame", ready_hi, 0);
      @(negedge clk_1Mhz);
      check("cmd_sent_width", cmd_sent, 0);
      check("cmd_ready_after_fin", cmd_ready, 1);
      exp_q = {code, 8'h30 + 8'(v0), 8'h3A, 8'h30 + 8'(v1), 8'h0A};
      check("tx_byte_count", tx_log.size() - base, 5);
      for (int i = 0; i < 5 && base + i < tx_log.size(); i++)
        check($sformatf("tx_byte%0d", i), tx_log[base + i], exp_q[i]);
      check("tx_start_hold", hold_viol - hv, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_code = '0;
    cmd_val0 = '0;
    cmd_val1 = '0;
    rx_data = '0;
    rx_done = 1'b0;
    codes = '{CMD_A, CMD_B, CMD_C, CMD_D, CMD_L, 8'h00};
    repeat (3) @(negedge clk_1Mhz);
    check("rst.cmd_ready", cmd_ready, 1);
    check("rst.tx_start", tx_start, 0);
    check("rst.tx_data", tx_data, 0);
    check("rst.cmd_err", cmd_err, 0);
    check("rst.cmd_sent", cmd_sent, 0);
    check("rst.stat_valid", stat_valid, 0);
    check("rst.frame_err", frame_err, 0);
    check_status("rst");
    rst_n = 1'b1;

    // Threshold command at ~1 ms per byte.
    do_cmd(CMD_A, 4'd2, 4'd5);
    // LED with an out-of-range digit is dropped.
    do_cmd(CMD_L, 4'd1, 4'd2);

    rx_string("S:256010/", -1, 8, 0);
    exp_t = 25; exp_h = 60; exp_f = 1'b1; exp_hm = 1'b0;
    check_status("frame1");

    rx_string("S:2X", 3, -1, 0);
    check_status("after_bad_x");
    rx_string("S:123400/", -1, 8, 0);
    exp_t = 12; exp_h = 34; exp_f = 1'b0; exp_hm = 1'b0;
    check_status("frame2");

    rx_string("xy5\n", -1, -1, 0);
    check_status("idle_noise");

    rx_string("S:1S:456711/", 3, 11, 0);
    exp_t = 45; exp_h = 67; exp_f = 1'b1; exp_hm = 1'b1;
    check_status("resync");

    // Stall inside a frame.
    rx_string("S:2", -1, -1, 0);
`ifdef RX_TIMEOUT_EN
    to_found = 1'b0;
    to_cycle = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_1Mhz);
      #1;
      if (frame_err && !to_found) begin
        to_found = 1'b1;
        to_cycle = c;
      end
    end
    check("timeout_cycle", to_cycle, 50);
    check_status("after_timeout");
    rx_string("S:256010/", -1, 8, 0);
`else
    to_found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_1Mhz);
      if (frame_err) to_found = 1'b1;
    end
    check("no_timeout_err", to_found, 0);
    rx_string("56010/", -1, 5, 0);
`endif
    exp_t = 25; exp_h = 60; exp_f = 1'b1; exp_hm = 1'b0;
    check_status("after_stall");

    // Randomised commands.
    byte_time = $urandom_range(2, 12);
    for (int k = 0; k < 8; k++) begin
      int sel;
      logic [7:0] code;
      logic [3:0] a, b;
      sel = $urandom_range(0, 5);
      code = (sel == 5) ? 8'($urandom) : codes[sel];
      if ($urandom_range(0, 3) != 0) begin
        a = 4'($urandom_range(0, 9));
        b = 4'($urandom_range(0, 9));
      end else begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
      end
      do_cmd(code, a, b);
    end

    // Randomised status frames, about a third corrupted at a random slot.
    for (int k = 0; k < 8; k++) begin
      int t, h, bp;
      bit f, hm;
      string s;
      t = $urandom_range(0, 99);
      h = $urandom_range(0, 99);
      f = 1'($urandom_range(0, 1));
      hm = 1'($urandom_range(0, 1));
      bp = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : -1;
      s = $sformatf("S:%02d%02d%0d%0d/", t, h, f, hm);
      if (bp > 0) begin
        s.putc(bp, 8'h78);
        s = s.substr(0, bp);
        rx_string(s, bp, -1, 0);
      end else begin
        rx_string(s, -1, 8, 0);
        exp_t = t; exp_h = h; exp_f = f; exp_hm = hm;
      end
      check_status("rand_frame");
    end

    // Command and status frame together, rx_done on each tx_done.
    byte_time = 20;
    base_both = both_done;
    fork
      do_cmd(CMD_B, 4'd7, 4'd3);
      rx_string("S:990001/", -1, 8, 5);
    join
    check("coincident_done", both_done - base_both, 5);
    exp_t = 99; exp_h = 0; exp_f = 1'b0; exp_hm = 1'b1;
    check_status("concurrent");

    // Reset in the middle of a command frame.
    byte_time = 200;
    @(negedge clk_1Mhz);
    cmd_valid = 1'b1;
    cmd_code = CMD_C;
    cmd_val0 = 4'd4;
    cmd_val1 = 4'd4;
    @(negedge clk_1Mhz);
    cmd_valid = 1'b0;
    for (int c = 0; c < 50 && !tx_busy; c++) @(negedge clk_1Mhz);
    repeat (5) @(negedge clk_1Mhz);
    check("tx_start_midcmd", tx_start, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.tx_start", tx_start, 0);
    check("midrst.cmd_ready", cmd_ready, 1);
    exp_t = 0; exp_h = 0; exp_f = 1'b0; exp_hm = 1'b0;
    check_status("midrst");
    @(negedge clk_1Mhz);
    rst_n = 1'b1;
    @(negedge clk_1Mhz);
    check("postrst.tx_start", tx_start, 0);
    check("postrst.cmd_ready", cmd_ready, 1);
    byte_time = 5;
    do_cmd(CMD_D, 4'd9, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
